// File: rtl/rtc_bus_scheduler.sv
// Sequencer and arbiter for the RTC multiplexed address/data bus: periodic
// refresh scan of the time/date/timer registers plus single-register writes.
module rtc_bus_scheduler #(
    parameter int T_PHASE     = 10,
    parameter int REFRESH_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       scan_en,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       scan_done,
    output logic       busy,
    inout  wire  [7:0] dato,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr
);

    localparam int PW = $clog2(T_PHASE);
    localparam int RW = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0] PH_LAST = PW'(T_PHASE - 1);
    localparam logic [PW-1:0] PH_ACK  = PW'(T_PHASE - 2);
    localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);

    // Sequential encoding: every active state advances to state+1, GAP2 returns to IDLE.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_GAP1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP2 = 3'd4;

    function automatic logic [7:0] scan_addr(input logic [3:0] i);
        case (i)
            4'd0:    scan_addr = 8'h21;
            4'd1:    scan_addr = 8'h22;
            4'd2:    scan_addr = 8'h23;
            4'd3:    scan_addr = 8'h24;
            4'd4:    scan_addr = 8'h25;
            4'd5:    scan_addr = 8'h26;
            4'd6:    scan_addr = 8'h27;
            4'd7:    scan_addr = 8'h41;
            4'd8:    scan_addr = 8'h42;
            4'd9:    scan_addr = 8'h43;
            default: scan_addr = 8'h21;
        endcase
    endfunction

    logic [2:0]    state, state_nx;
    logic [PW-1:0] cnt, cnt_nx;
    logic          xact_wr, xact_wr_nx;
    logic [7:0]    addr_q, addr_nx;
    logic [7:0]    data_q, data_nx;
    logic [3:0]    idx;
    logic          scan_active, scan_pending;
    logic [RW-1:0] rcnt;
    logic          oe;
    logic [7:0]    dout;
    logic          start_rd, phase_end, read_end, rwrap;

    assign phase_end = (cnt == PH_LAST);
    assign read_end  = (state == S_DATA) && phase_end && !xact_wr;
    assign rwrap     = (rcnt == R_LAST);
    assign busy      = (state != S_IDLE);
    assign dato      = oe ? dout : 8'hzz;

    // NOTE: every variable gets a default before the case logic so no latch is inferred.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        xact_wr_nx = xact_wr;
        addr_nx    = addr_q;
        data_nx    = data_q;
        start_rd   = 1'b0;
        if (state == S_IDLE) begin
            if (wr_req) begin
                state_nx   = S_ADDR;
                cnt_nx     = '0;
                xact_wr_nx = 1'b1;
                addr_nx    = wr_addr;
                data_nx    = wr_data;
            end else if (scan_active || scan_pending) begin
                state_nx   = S_ADDR;
                cnt_nx     = '0;
                xact_wr_nx = 1'b0;
                addr_nx    = scan_addr(idx);
                start_rd   = 1'b1;
            end
        end else if (phase_end) begin
            cnt_nx   = '0;
            state_nx = (state == S_GAP2) ? S_IDLE : state + 3'd1;
        end else begin
            cnt_nx = cnt + PW'(1);
        end
    end

    // NOTE: state and pins use non-blocking assignments; pins are decoded from the
    // next state so they change on the same edge as the state, glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            xact_wr <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            a_d     <= 1'b1;
            cs      <= 1'b1;
            rd      <= 1'b1;
            wr      <= 1'b1;
            oe      <= 1'b0;
            dout    <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            xact_wr <= xact_wr_nx;
            addr_q  <= addr_nx;
            data_q  <= data_nx;
            a_d     <= !((state_nx == S_ADDR) || (state_nx == S_GAP1));
            cs      <= !((state_nx == S_ADDR) || (state_nx == S_DATA));
            wr      <= !((state_nx == S_ADDR) || ((state_nx == S_DATA) && xact_wr_nx));
            rd      <= !((state_nx == S_DATA) && !xact_wr_nx);
            oe      <= (state_nx == S_ADDR) || ((state_nx == S_DATA) && xact_wr_nx);
            dout    <= (state_nx == S_ADDR) ? addr_nx : data_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid  <= 1'b0;
            scan_done <= 1'b0;
            wr_ack    <= 1'b0;
            rd_addr   <= 8'h00;
            rd_data   <= 8'h00;
            idx       <= 4'd0;
        end else begin
            rd_valid  <= 1'b0;
            scan_done <= 1'b0;
            wr_ack    <= (state == S_GAP2) && xact_wr && (cnt == PH_ACK);
            if (read_end) begin
                rd_data  <= dato;
                rd_addr  <= addr_q;
                rd_valid <= 1'b1;
                if (idx == 4'd9) begin
                    idx       <= 4'd0;
                    scan_done <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    // Refresh trigger: a wrap only arms a scan when none is running or queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt         <= '0;
            scan_pending <= 1'b0;
            scan_active  <= 1'b0;
        end else begin
            rcnt <= rwrap ? '0 : rcnt + RW'(1);

            if (start_rd && scan_pending)
                scan_active <= 1'b1;
            else if (read_end && (idx == 4'd9))
                scan_active <= 1'b0;

            if (!scan_en)
                scan_pending <= 1'b0;
            else if (start_rd && scan_pending)
                scan_pending <= 1'b0;
            else if (rwrap && !scan_active && !scan_pending)
                scan_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: RTC bus model answers reads with addr+1,
// expected transactions are queued by the stimulus and popped by a monitor.
module tb_rtc_bus_scheduler;

    logic       clk, reset;
    logic       wr_req, scan_en;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack, rd_valid, scan_done, busy;
    logic [7:0] rd_addr, rd_data;
    logic       a_d, cs, rd, wr;
    tri1  [7:0] dato;   // pulled high, so a released bus reads 8'hFF

    rtc_bus_scheduler #(.T_PHASE(4), .REFRESH_DIV(150)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .scan_en(scan_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .scan_done(scan_done), .busy(busy),
        .dato(dato), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC model: latch address in ADDR phase, drive addr+1 while rd is low, capture writes.
    logic [7:0] mdl_addr, mdl_wdata, mdl_rdata;
    assign mdl_rdata = mdl_addr + 8'd1;
    assign dato = !rd ? mdl_rdata : 8'hzz;
    always @(posedge clk) begin
        if (!cs && !a_d) mdl_addr <= dato;
        if (!cs && a_d && !wr) mdl_wdata <= dato;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] scan_tbl [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                  8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
    logic [7:0] data_tbl [10] = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                  8'h27, 8'h28, 8'h42, 8'h43, 8'h44};

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (rd_valid || wr_ack)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {30'b0, wr_ack, rd_valid}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.is_wr ? "sb_write" : "sb_read",
                      {14'b0, wr_ack,
                       wr_ack ? mdl_addr  : rd_addr,
                       wr_ack ? mdl_wdata : rd_data,
                       scan_done},
                      {14'b0, mon_e});
            end
        end
    end

    task automatic push_scan(input int wr_after, input logic [7:0] wa, input logic [7:0] wd);
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{1'b0, scan_tbl[i], data_tbl[i], (i == 9)});
            if (i == wr_after) sb.push_back('{1'b1, wa, wd, 1'b0});
        end
    endtask

    task automatic wait_cs_low(input string name);
        bit ok = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!cs) begin ok = 1; break; end
        end
        if (!ok) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_ack_and_drop(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wr_ack) begin ok = 1; break; end
        end
        if (!ok) check(name, 32'd0, 32'd1);
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic wait_scan_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (scan_done) begin ok = 1; break; end
        end
        if (!ok) check(name, 32'd0, 32'd1);
    endtask

    function automatic logic [12:0] wr_wave(input int c);
        // {a_d, cs, rd, wr, wr_ack, dato} for cycle c (1..16) of a write
        if (c <= 4)       return {5'b00100, 8'h22};
        else if (c <= 8)  return {5'b01110, 8'hFF};
        else if (c <= 12) return {5'b10100, 8'h45};
        else if (c <= 15) return {5'b11110, 8'hFF};
        else              return {5'b11111, 8'hFF};
    endfunction

    int  idle_run;
    bit  ok_flag;
    bit  busy_seen;

    initial begin
        reset = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; scan_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {a_d, cs, rd, wr, wr_ack, rd_valid, scan_done, busy, rd_addr, rd_data, dato},
              32'hF0_0000_FF);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Write aborted by reset in its ADDR phase: never acknowledged.
        #1 wr_addr = 8'h30; wr_data = 8'h11; wr_req = 1'b1;
        wait_cs_low("abort_grant_timeout");
        #1 reset = 1'b0;
        #1 check("reset_mid_addr_pins", {19'b0, a_d, cs, rd, wr, dato}, {19'b0, 4'hF, 8'hFF});
        wr_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("busy_after_abort", {31'b0, busy}, 32'd0);

        // Single write 0x22 <= 0x45, checked pin by pin over its 16 cycles.
        sb.push_back('{1'b1, 8'h22, 8'h45, 1'b0});
        @(posedge clk);
        #1 wr_addr = 8'h22; wr_data = 8'h45; wr_req = 1'b1;
        wait_cs_low("write_grant_timeout");
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("write_cycle_%0d", c),
                  {19'b0, a_d, cs, rd, wr, wr_ack, dato}, {19'b0, wr_wave(c)});
        end
        @(posedge clk);
        #1 wr_req = 1'b0;
        repeat (5) @(posedge clk);

        // Two scans: the first plain, the second pre-empted by a write after 0x24.
        push_scan(-1, 8'h00, 8'h00);
        push_scan(3, 8'h30, 8'h5A);
        #1 scan_en = 1'b1;
        wait_scan_done("scan1_timeout");

        // Wrap mid-scan is dropped; the next scan waits for the following wrap.
        ok_flag = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin ok_flag = 1; break; end
        end
        idle_run = 0;
        while (ok_flag && !busy && idle_run < 400) begin
            idle_run++;
            @(negedge clk);
        end
        check("idle_between_scans", idle_run, 32'd131);

        ok_flag = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cs && !a_d && dato == 8'h24) begin ok_flag = 1; break; end
        end
        if (!ok_flag) check("addr_0x24_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 wr_addr = 8'h30; wr_data = 8'h5A; wr_req = 1'b1;
        wait_ack_and_drop("scan_write_ack_timeout");
        wait_scan_done("scan2_timeout");
        @(posedge clk);
        #1 scan_en = 1'b0;

        // Disabled scanning: wraps must not start any transaction.
        repeat (10) @(posedge clk);
        busy_seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("scan_disabled_busy", {31'b0, busy_seen}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
